// File: rtl/alu_stage_pkg.sv
// Shared flag layout and occupancy encoding for the ALU result stage.
// Imported by the interface, the flag generator and the stage top.
package alu_stage_pkg;

  localparam int FLAG_W = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// Adder-to-writeback bundle: input valid/ready with operands and sum,
// output valid/ready with result and flags.
interface alu_result_stage_if #(
  parameter int WIDTH = 8
);
  import alu_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              Cin;
  logic [WIDTH-1:0]  Sum;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  Result;
  logic [FLAG_W-1:0] Flags;

  modport master (
    output in_valid, A, B, Cin, Sum, out_ready,
    input  in_ready, out_valid, Result, Flags
  );

  modport slave (
    input  in_valid, A, B, Cin, Sum, out_ready,
    output in_ready, out_valid, Result, Flags
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/C/V derivation from adder operands and sum.
// Carry is reconstructed from the MSBs, so Cin is not needed.
module alu_flag_gen
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [WIDTH-1:0]  Sum,
  output logic [FLAG_W-1:0] Flags
);

  localparam int MSB = WIDTH - 1;

  logic am, bm, sm;

  assign am = A[MSB];
  assign bm = B[MSB];
  assign sm = Sum[MSB];

  always_comb begin
    Flags         = '0;
    Flags[FLAG_Z] = (Sum == '0);
    Flags[FLAG_N] = sm;
    Flags[FLAG_C] = (am & bm) | ((am | bm) & ~sm);
    Flags[FLAG_V] = (am == bm) & (sm != am);
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result/flag stage with 2-entry skid buffer (OUT + SKID).
// ALU_STAGE_CHECK_EN adds a sum re-check and the err_sticky port.
module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_stage_if.slave    bus
`ifdef ALU_STAGE_CHECK_EN
  ,
  output logic                 err_sticky
`endif
);

  occ_e              state_q, state_d;
  logic              rdy_q;
  logic              acc;
  logic              ld_out, ld_skid, mv_skid;
  logic [FLAG_W-1:0] flags;
  logic [WIDTH-1:0]  out_res_q, skid_res_q;
  logic [FLAG_W-1:0] out_flg_q, skid_flg_q;

  assign acc = bus.in_valid & rdy_q;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
    .A     (bus.A),
    .B     (bus.B),
    .Sum   (bus.Sum),
    .Flags (flags)
  );

  always_comb begin
    state_d = state_q;
    ld_out  = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          ld_out  = 1'b1;
          state_d = HALF;
        end
      end
      HALF: begin
        if (bus.out_ready) begin
          if (acc) ld_out = 1'b1;
          else     state_d = EMPTY;
        end else if (acc) begin
          ld_skid = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          mv_skid = 1'b1;
          state_d = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is a flop, looking one state ahead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rdy_q      <= 1'b1;
      out_res_q  <= '0;
      out_flg_q  <= '0;
      skid_res_q <= '0;
      skid_flg_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
      if (ld_out) begin
        out_res_q <= bus.Sum;
        out_flg_q <= flags;
      end else if (mv_skid) begin
        out_res_q <= skid_res_q;
        out_flg_q <= skid_flg_q;
      end
      if (ld_skid) begin
        skid_res_q <= bus.Sum;
        skid_flg_q <= flags;
      end
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.Result    = out_res_q;
  assign bus.Flags     = out_flg_q;

`ifdef ALU_STAGE_CHECK_EN
  logic [WIDTH:0] chk_sum;
  logic           chk_bad;

  assign chk_sum = {1'b0, bus.A} + {1'b0, bus.B}
                 + {{WIDTH{1'b0}}, bus.Cin};
  assign chk_bad = (chk_sum[WIDTH-1:0] != bus.Sum)
                 | (chk_sum[WIDTH] != flags[FLAG_C]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             err_sticky <= 1'b0;
    else if (acc & chk_bad) err_sticky <= 1'b1;
  end
`else
  logic unused_cin;
  assign unused_cin = bus.Cin;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed vectors,
// expected {Result,Flags} queued at accept, popped by a monitor.
module tb_alu_result_stage;
  import alu_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_stage_if #(.WIDTH(8)) bus ();

`ifdef ALU_STAGE_CHECK_EN
  logic err;
`endif

  alu_result_stage #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef ALU_STAGE_CHECK_EN
    ,
    .err_sticky (err)
`endif
  );

  int total = 0;
  int bad = 0;
  int pops = 0;
  logic [11:0] q[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Independent reference: true 9-bit add and signed range test
  function automatic logic [3:0] model(logic [7:0] a,
      logic [7:0] b, logic cin, logic [7:0] sum);
    logic [8:0] full;
    int s;
    full = {1'b0, a} + {1'b0, b} + 9'(cin);
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    model = {(s > 127 || s < -128), full[8], sum[7], sum == 8'h00};
  endfunction

  always @(negedge clk) begin : mon
    logic [11:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h want none",
                 bus.Result);
      end else begin
        e = q.pop_front();
        chk("sb_result", 32'(bus.Result), 32'(e[11:4]));
        chk("sb_flags", 32'(bus.Flags), 32'(e[3:0]));
        pops++;
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [7:0] a, logic [7:0] b, logic cin,
                      logic [7:0] sum, logic [3:0] flg);
    int n;
    n = 0;
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
    bus.Sum = sum;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end else begin
      q.push_back({sum, flg});
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin : stim
    int p0;
    bus.in_valid = 1'b1;
    bus.A = 8'h55;
    bus.B = 8'h33;
    bus.Cin = 1'b0;
    bus.Sum = 8'h12;
    bus.out_ready = 1'b1;
    idle(3);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_flags", 32'(bus.Flags), 0);
    chk("rst_result", 32'(bus.Result), 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    idle(1);

    send(8'h7F, 8'h01, 1'b0, 8'h80, 4'b1010);
    chk("lat_valid", 32'(bus.out_valid), 1);
    chk("lat_result", 32'(bus.Result), 32'h80);
    send(8'hFF, 8'h01, 1'b0, 8'h00, 4'b0101);
    idle(2);

    bus.A = 8'hAA;
    bus.Sum = 8'hAA;
    idle(3);
    chk("idle_valid", 32'(bus.out_valid), 0);
    chk("idle_q", 32'(q.size()), 0);

    bus.out_ready = 1'b0;
    send(8'h11, 8'h00, 1'b0, 8'h11, model(8'h11, 8'h00, 0, 8'h11));
    send(8'h22, 8'h00, 1'b0, 8'h22, model(8'h22, 8'h00, 0, 8'h22));
    bus.A = 8'h33;
    bus.B = 8'h00;
    bus.Sum = 8'h33;
    bus.in_valid = 1'b1;
    idle(2);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_out_valid", 32'(bus.out_valid), 1);
    chk("bp_hold_result", 32'(bus.Result), 32'h11);
    bus.out_ready = 1'b1;
    send(8'h33, 8'h00, 1'b0, 8'h33, model(8'h33, 8'h00, 0, 8'h33));
    idle(3);
    chk("bp_drained", 32'(q.size()), 0);

    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] a;
      logic [7:0] s;
      a = 8'h70 + 8'(i);
      s = a + 8'h08;
      chk("tput_ready", 32'(bus.in_ready), 1);
      send(a, 8'h08, 1'b0, s, model(a, 8'h08, 1'b0, s));
    end
    idle(3);
    chk("tput_count", 32'(pops - p0), 16);
    chk("tput_empty", 32'(bus.out_valid), 0);

`ifdef ALU_STAGE_CHECK_EN
    chk("err_clean", 32'(err), 0);
    send(8'h10, 8'h10, 1'b0, 8'h21, 4'b0000);
    idle(2);
    chk("err_set", 32'(err), 1);
    idle(3);
    chk("err_hold", 32'(err), 1);
`endif

    bus.out_ready = 1'b0;
    send(8'h44, 8'h00, 1'b0, 8'h44, 4'b0000);
    send(8'h55, 8'h00, 1'b0, 8'h55, 4'b0000);
    chk("mr_full", 32'(bus.in_ready), 0);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mr_out_valid", 32'(bus.out_valid), 0);
    chk("mr_in_ready", 32'(bus.in_ready), 1);
    chk("mr_result", 32'(bus.Result), 0);
`ifdef ALU_STAGE_CHECK_EN
    chk("mr_err", 32'(err), 0);
`endif
    idle(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(3);
    chk("mr_no_partial", 32'(bus.out_valid), 0);
    send(8'h01, 8'h01, 1'b0, 8'h02, model(8'h01, 8'h01, 0, 8'h02));
    idle(2);
    chk("mr_recover", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
